axis_downsizer_flex: RTL and testbench

AXIS_DOWNSIZER_FLEX -- requirements
Module: axis_downsizer_flex

---
 rtl/axis_downsizer_flex_pkg.sv | 10 +
 rtl/axis_downsizer_flex_reg_slice.sv | 32 +++
 rtl/axis_downsizer_flex.sv | 93 +++++++++
 tb/tb_axis_downsizer_flex.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_downsizer_flex_pkg.sv
// Shared helper for the AXI-Stream width downsizer.
// Holds only elaboration-time functions; geometry stays local to each instance.
package axis_downsizer_flex_pkg;

  // Slice counter width: clog2(ratio), never narrower than one bit.
  function automatic int cntr_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/axis_downsizer_flex_reg_slice.sv
// One-entry valid/ready register stage; accepts a new entry whenever it is
// empty or its current entry is being taken on the same cycle.
module axis_reg_slice #(
  parameter int WIDTH = 33
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  assign in_ready = ~out_valid | out_ready;

  // NOTE: registered state is written with <= only, so every reader sees the
  // pre-edge value and simulation matches the synthesized flops.
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/axis_downsizer_flex.sv
// AXI-Stream downsizer: splits each wide input beat into a runtime-selectable
// number of narrow output words, LSB-first or MSB-first.
module axis_downsizer_flex
  import axis_downsizer_flex_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 128,
  parameter int M_AXIS_TDATA_WIDTH = 32,
  parameter bit MSB_FIRST          = 1'b0
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [15:0]                   cfg_data,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [31:0]                   sts_data
);

  localparam int M     = M_AXIS_TDATA_WIDTH;
  localparam int RATIO = S_AXIS_TDATA_WIDTH / M_AXIS_TDATA_WIDTH;
  localparam int CW    = cntr_width(RATIO);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  logic [CW-1:0] cntr;
  logic [CW-1:0] n_eff_q;
  logic [CW-1:0] n_cfg;
  logic [CW-1:0] n_eff;
  logic          last_slice;
  logic          stage_ready;
  logic          slice_accept;
  logic [M-1:0]  slice_data;
  logic [M-1:0]  slices [RATIO];
  logic          unused_cfg;

  assign unused_cfg = ^cfg_data[15:CW];

  // Word count is clamped to the beat geometry and frozen after slice 0.
  assign n_cfg = cfg_data[CW-1:0];
  assign n_eff = (cntr == '0) ? ((n_cfg > LAST_IDX) ? LAST_IDX : n_cfg) : n_eff_q;

  assign last_slice    = (cntr == n_eff);
  assign slice_accept  = s_axis_tvalid & stage_ready;
  assign s_axis_tready = last_slice & stage_ready & ~areset;

  for (genvar i = 0; i < RATIO; i++) begin : g_slice
    assign slices[i] = s_axis_tdata[i*M +: M];
  end

  if (RATIO == 1) begin : g_pass
    assign slice_data = slices[0];
  end else begin : g_mux
    logic [CW-1:0] slice_idx;
    assign slice_idx  = MSB_FIRST ? (n_eff - cntr) : cntr;
    assign slice_data = slices[slice_idx];
  end

  axis_reg_slice #(
    .WIDTH (M + 1)
  ) u_out_stage (
    .aclk      (aclk),
    .areset    (areset),
    .in_data   ({s_axis_tlast & last_slice, slice_data}),
    .in_valid  (s_axis_tvalid),
    .in_ready  (stage_ready),
    .out_data  ({m_axis_tlast, m_axis_tdata}),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      cntr     <= '0;
      n_eff_q  <= '0;
      sts_data <= '0;
    end else begin
      if (slice_accept) begin
        cntr <= last_slice ? '0 : cntr + CW'(1);
        if (cntr == '0) begin
          n_eff_q <= n_eff;
        end
      end
      if (s_axis_tvalid & s_axis_tready) begin
        sts_data <= sts_data + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_downsizer_flex.sv
// Directed bench for axis_downsizer_flex: LSB-first and MSB-first 128->32
// instances plus a 32->32 pass-through, driven one at a time through sel.
module tb_axis_downsizer_flex;

  localparam logic [127:0] BEAT = 128'h44444444_33333333_22222222_11111111;
  localparam logic [31:0]  W1 = 32'h11111111;
  localparam logic [31:0]  W2 = 32'h22222222;
  localparam logic [31:0]  W3 = 32'h33333333;
  localparam logic [31:0]  W4 = 32'h44444444;

  logic         aclk;
  logic         areset;
  logic [15:0]  cfg_data;
  logic [127:0] s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         m_tready;
  int           sel;

  logic [2:0]   s_tready_v, m_tvalid_v, m_tlast_v;
  logic [31:0]  m_tdata_v [3];
  logic [31:0]  sts_v [3];

  logic         s_tready_sel, m_tvalid_sel, m_tlast_sel;
  logic [31:0]  m_tdata_sel, sts_sel;

  int checks = 0;
  int errors = 0;
  int exp_sts [3] = '{0, 0, 0};

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  axis_downsizer_flex #(.S_AXIS_TDATA_WIDTH(128), .M_AXIS_TDATA_WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
    .aclk(aclk), .areset(areset), .cfg_data(cfg_data),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && sel == 0), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready_v[0]),
    .m_axis_tdata(m_tdata_v[0]), .m_axis_tvalid(m_tvalid_v[0]), .m_axis_tlast(m_tlast_v[0]),
    .m_axis_tready(m_tready), .sts_data(sts_v[0])
  );

  axis_downsizer_flex #(.S_AXIS_TDATA_WIDTH(128), .M_AXIS_TDATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
    .aclk(aclk), .areset(areset), .cfg_data(cfg_data),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && sel == 1), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready_v[1]),
    .m_axis_tdata(m_tdata_v[1]), .m_axis_tvalid(m_tvalid_v[1]), .m_axis_tlast(m_tlast_v[1]),
    .m_axis_tready(m_tready), .sts_data(sts_v[1])
  );

  axis_downsizer_flex #(.S_AXIS_TDATA_WIDTH(32), .M_AXIS_TDATA_WIDTH(32), .MSB_FIRST(1'b0)) dut_pass (
    .aclk(aclk), .areset(areset), .cfg_data(cfg_data),
    .s_axis_tdata(s_tdata[31:0]), .s_axis_tvalid(s_tvalid && sel == 2), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready_v[2]),
    .m_axis_tdata(m_tdata_v[2]), .m_axis_tvalid(m_tvalid_v[2]), .m_axis_tlast(m_tlast_v[2]),
    .m_axis_tready(m_tready), .sts_data(sts_v[2])
  );

  always_comb begin
    s_tready_sel = s_tready_v[sel];
    m_tvalid_sel = m_tvalid_v[sel];
    m_tlast_sel  = m_tlast_v[sel];
    m_tdata_sel  = m_tdata_v[sel];
    sts_sel      = sts_v[sel];
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [31:0] data, input logic last);
    check({tag, " m_tvalid"}, {31'd0, m_tvalid_sel}, 32'd1);
    check({tag, " m_tdata"}, m_tdata_sel, data);
    check({tag, " m_tlast"}, {31'd0, m_tlast_sel}, {31'd0, last});
  endtask

  // Presents one beat with m_tready high and checks every output word, the
  // single s_tready pulse and the consumed-beat count. Optionally changes
  // cfg_data at the start of slice chg_k.
  task automatic run_beat(input string tag, input logic [127:0] data, input logic last,
                          input logic [15:0] cfg, input int nwords,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3,
                          input int chg_k, input logic [15:0] chg_cfg);
    logic [31:0] exp_w [4];
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
    cfg_data = cfg;
    s_tdata  = data;
    s_tlast  = last;
    s_tvalid = 1'b1;
    for (int k = 0; k < nwords; k++) begin
      if (k == chg_k) cfg_data = chg_cfg;
      #1;
      check($sformatf("%s s_tready slice%0d", tag, k), {31'd0, s_tready_sel},
            (k == nwords - 1) ? 32'd1 : 32'd0);
      step();
      check_word($sformatf("%s word%0d", tag, k), exp_w[k], (k == nwords - 1) ? last : 1'b0);
      if (k == nwords - 1) begin
        s_tvalid = 1'b0;
        exp_sts[sel]++;
        check({tag, " sts_data"}, sts_sel, 32'(exp_sts[sel]));
      end
    end
  endtask

  task automatic check_idle(input string tag);
    step();
    check({tag, " drained"}, {31'd0, m_tvalid_sel}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel      = 0;
    areset   = 1'b1;
    cfg_data = 16'd3;
    s_tdata  = BEAT;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    m_tready = 1'b1;

    // Reset state, with a valid beat waiting that must not be taken.
    step();
    check("reset s_tready", {31'd0, s_tready_sel}, 32'd0);
    check("reset m_tvalid", {31'd0, m_tvalid_sel}, 32'd0);
    check("reset m_tdata", m_tdata_sel, 32'd0);
    check("reset m_tlast", {31'd0, m_tlast_sel}, 32'd0);
    check("reset sts_data", sts_sel, 32'd0);
    areset   = 1'b0;
    s_tvalid = 1'b0;
    step();
    check("post-reset m_tvalid", {31'd0, m_tvalid_sel}, 32'd0);

    // LSB-first full beat, then cfg above RATIO-1 clamps to four words.
    run_beat("lsb cfg3", BEAT, 1'b1, 16'd3, 4, W1, W2, W3, W4, -1, 16'd0);
    check_idle("lsb cfg3");
    run_beat("lsb cfg7", BEAT, 1'b1, 16'd7, 4, W1, W2, W3, W4, -1, 16'd0);
    check_idle("lsb cfg7");

    // Back-pressure for three cycles after the first word.
    cfg_data = 16'd3;
    s_tdata  = BEAT;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    #1;
    check("stall s_tready slice0", {31'd0, s_tready_sel}, 32'd0);
    step();
    check_word("stall word0", W1, 1'b0);
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_word($sformatf("stall hold%0d", i), W1, 1'b0);
      check($sformatf("stall hold%0d s_tready", i), {31'd0, s_tready_sel}, 32'd0);
    end
    m_tready = 1'b1;
    step();
    check_word("stall word1", W2, 1'b0);
    check("stall s_tready slice2", {31'd0, s_tready_sel}, 32'd0);
    step();
    check_word("stall word2", W3, 1'b0);
    check("stall s_tready slice3", {31'd0, s_tready_sel}, 32'd1);
    step();
    check_word("stall word3", W4, 1'b1);
    s_tvalid = 1'b0;
    exp_sts[0]++;
    check("stall sts_data", sts_sel, 32'(exp_sts[0]));
    check_idle("stall");

    // cfg drops to 0 mid-beat: this beat keeps four words, the next has one.
    run_beat("cfgchg beatA", BEAT, 1'b1, 16'd3, 4, W1, W2, W3, W4, 2, 16'd0);
    run_beat("cfgchg beatB", 128'h0_0_0_A5A5A5A5, 1'b0, 16'd0, 1,
             32'hA5A5A5A5, 32'd0, 32'd0, 32'd0, -1, 16'd0);
    check_idle("cfgchg");

    // Reset after the second slice; the same beat restarts from slice 0.
    cfg_data = 16'd3;
    s_tdata  = BEAT;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    step();
    check_word("midrst word0", W1, 1'b0);
    step();
    check_word("midrst word1", W2, 1'b0);
    areset = 1'b1;
    #1;
    check("midrst s_tready in reset", {31'd0, s_tready_sel}, 32'd0);
    step();
    check("midrst m_tvalid", {31'd0, m_tvalid_sel}, 32'd0);
    check("midrst m_tdata", m_tdata_sel, 32'd0);
    check("midrst sts_data", sts_sel, 32'd0);
    areset  = 1'b0;
    exp_sts = '{0, 0, 0};
    run_beat("midrst replay", BEAT, 1'b1, 16'd3, 4, W1, W2, W3, W4, -1, 16'd0);
    check_idle("midrst");

    // MSB-first instance.
    sel = 1;
    run_beat("msb cfg1", BEAT, 1'b1, 16'd1, 2, W2, W1, 32'd0, 32'd0, -1, 16'd0);
    run_beat("msb cfg3", BEAT, 1'b0, 16'd3, 4, W4, W3, W2, W1, -1, 16'd0);
    run_beat("msb cfg0", BEAT, 1'b1, 16'd0, 1, W1, 32'd0, 32'd0, 32'd0, -1, 16'd0);
    check_idle("msb");

    // RATIO = 1 pass-through ignores cfg and forwards tlast.
    sel = 2;
    run_beat("pass last1", 128'h0_0_0_DEADBEEF, 1'b1, 16'd5, 1,
             32'hDEADBEEF, 32'd0, 32'd0, 32'd0, -1, 16'd0);
    run_beat("pass last0", 128'h0_0_0_0BADF00D, 1'b0, 16'd2, 1,
             32'h0BADF00D, 32'd0, 32'd0, 32'd0, -1, 16'd0);
    check_idle("pass");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
